// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 20000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          ack,
   output logic                        tx_err,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
   output logic                        send,
   output logic [DATA_W-1:0]           dintx,
   input  logic                        donetx
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int WD_W = $clog2(TIMEOUT);
   // Expiry is detected one count early so tx_err lands exactly TIMEOUT cycles after send.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [WD_W-1:0] wdog;
   logic [ID_W-1:0] pick;
   logic [ID_W-1:0] next_ptr;
   logic            found_hi;
   logic            found_lo;

   // First pass searches [ptr, NUM_REQ), second pass wraps to [0, ptr).
   always_comb begin
      pick     = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found_hi && req[i] && (ID_W'(i) >= ptr)) begin
            found_hi = 1'b1;
            pick     = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found_hi && !found_lo && req[i] && (ID_W'(i) < ptr)) begin
            found_lo = 1'b1;
            pick     = ID_W'(i);
         end
      end
   end

   assign next_ptr = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         ptr    <= '0;
         wdog   <= '0;
         send   <= 1'b0;
         dintx  <= '0;
         ack    <= '0;
         tx_err <= 1'b0;
         busy   <= 1'b0;
         gnt_id <= '0;
      end else begin
         send   <= 1'b0;
         ack    <= '0;
         tx_err <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state  <= SEND;
                  send   <= 1'b1;
                  busy   <= 1'b1;
                  gnt_id <= pick;
                  dintx  <= req_data[pick*DATA_W +: DATA_W];
               end
            end
            SEND: begin
               wdog  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (donetx) begin
                  ack   <= NUM_REQ'(1) << gnt_id;
                  ptr   <= next_ptr;
                  state <= DONE;
               end else if (wdog == WD_LAST) begin
                  tx_err <= 1'b1;
                  ptr    <= next_ptr;
                  state  <= DONE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NR-1:0] req = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic          donetx = 1'b0;
   logic [NR-1:0] ack;
   logic          tx_err;
   logic          busy;
   logic [1:0]    gnt_id;
   logic          send;
   logic [DW-1:0] dintx;

   int assertions = 0;
   int failures   = 0;
   int viol       = 0;

   int         exp_id[$];
   logic [7:0] exp_data[$];
   int         mon_id[$];
   logic [7:0] mon_data[$];

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
      .tx_err(tx_err), .busy(busy), .gnt_id(gnt_id), .send(send),
      .dintx(dintx), .donetx(donetx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         if (send) begin
            mon_id.push_back(int'(gnt_id));
            mon_data.push_back(dintx);
         end
         if (((ack != '0) && tx_err) || !$onehot0(ack)) viol++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; req = '0; donetx = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic wait_send(output bit got);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (send) got = 1'b1;
         else tick();
      end
   endtask

   task automatic respond(input int dly, output bit got);
      wait_send(got);
      if (got) begin
         repeat (dly) tick();
         donetx = 1'b1;
         tick();
         donetx = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '0; donetx = 1'b0;
      tick(); tick();
      assertions++; if (send !== 1'b0) begin failures++; $display("FAIL reset_send: got %b want 0", send); end
      assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      assertions++; if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack: got %b want 0000", ack); end
      assertions++; if (tx_err !== 1'b0) begin failures++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
      assertions++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
      assertions++; if (dintx !== 8'h00) begin failures++; $display("FAIL reset_dintx: got %h want 00", dintx); end
      rst = 1'b1;
      tick(); tick();
      assertions++; if ({send, busy} !== 2'b00) begin failures++; $display("FAIL idle_no_req: send/busy got %b want 00", {send, busy}); end
   endtask

   task automatic test_single();
      bit got;
      do_reset();
      req_data = '0; req_data[2*DW +: DW] = 8'hA5;
      req = 4'b0100;
      exp_id.push_back(2); exp_data.push_back(8'hA5);
      wait_send(got);
      assertions++; if (!got) begin failures++; $display("FAIL single_send: no send seen"); end
      assertions++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_send: got %b want 1", busy); end
      repeat (10) tick();
      donetx = 1'b1;
      tick();
      donetx = 1'b0;
      assertions++; if (ack !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b want 0100", ack); end
      assertions++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_in_done: got %b want 1", busy); end
      req = '0;
      tick();
      assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_low: got %b want 0", busy); end
      assertions++; if (ack !== 4'b0000) begin failures++; $display("FAIL single_ack_one_cycle: got %b want 0000", ack); end
      tick(); tick();
      assertions++; if (mon_id.size() != exp_id.size()) begin failures++; $display("FAIL single_send_count: got %0d want %0d", mon_id.size(), exp_id.size()); end
   endtask

   task automatic test_all_four();
      bit got;
      int nacks;
      logic [3:0] onehot;
      do_reset();
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      nacks = 0;
      for (int k = 0; k < 4; k++) begin
         exp_id.push_back(k); exp_data.push_back(8'h11 * (k + 1));
      end
      for (int k = 0; k < 4; k++) begin
         onehot = 4'(1 << k);
         respond(3, got);
         assertions++; if (!got) begin failures++; $display("FAIL all4_send_%0d: no send seen", k); end
         assertions++; if (ack !== onehot) begin failures++; $display("FAIL all4_ack_%0d: got %b want %b", k, ack, onehot); end
         if (ack != '0) nacks++;
         req = req & ~ack;
      end
      repeat (6) tick();
      assertions++; if (nacks != 4) begin failures++; $display("FAIL all4_ack_count: got %0d want 4", nacks); end
      assertions++; if (mon_id.size() != exp_id.size()) begin failures++; $display("FAIL all4_send_count: got %0d want %0d", mon_id.size(), exp_id.size()); end
   endtask

   task automatic test_fairness();
      bit got;
      int id;
      logic [3:0] onehot;
      do_reset();
      req_data = '0; req_data[0 +: DW] = 8'hA0; req_data[3*DW +: DW] = 8'hD3;
      req = 4'b1001;
      for (int k = 0; k < 6; k++) begin
         id = (k % 2 == 1) ? 3 : 0;
         onehot = 4'(1 << id);
         exp_id.push_back(id); exp_data.push_back((id == 3) ? 8'hD3 : 8'hA0);
         respond(2, got);
         assertions++; if (!got) begin failures++; $display("FAIL fair_send_%0d: no send seen", k); end
         assertions++; if (ack !== onehot) begin failures++; $display("FAIL fair_ack_%0d: got %b want %b", k, ack, onehot); end
      end
      req = '0;
      repeat (4) tick();
      assertions++; if (mon_id.size() != exp_id.size()) begin failures++; $display("FAIL fair_send_count: got %0d want %0d", mon_id.size(), exp_id.size()); end
   endtask

   task automatic test_timeout();
      bit got;
      bit ack_seen;
      int k;
      do_reset();
      req_data = '0; req_data[DW +: DW] = 8'h5A;
      req = 4'b0010;
      exp_id.push_back(1); exp_data.push_back(8'h5A);
      wait_send(got);
      assertions++; if (!got) begin failures++; $display("FAIL to_send: no send seen"); end
      k = 0; ack_seen = 1'b0;
      while (!tx_err && k < 40) begin
         tick();
         k++;
         if (ack != '0) ack_seen = 1'b1;
      end
      assertions++; if (k != TO) begin failures++; $display("FAIL to_latency: tx_err after %0d cycles want %0d", k, TO); end
      assertions++; if (ack_seen) begin failures++; $display("FAIL to_no_ack: ack seen %b want none", ack_seen); end
      exp_id.push_back(1); exp_data.push_back(8'h5A);
      respond(4, got);
      assertions++; if (!got) begin failures++; $display("FAIL to_retry_send: no send seen"); end
      assertions++; if (ack !== 4'b0010) begin failures++; $display("FAIL to_retry_ack: got %b want 0010", ack); end
      assertions++; if (tx_err !== 1'b0) begin failures++; $display("FAIL to_retry_err: got %b want 0", tx_err); end
      req = '0;
      repeat (4) tick();
   endtask

   task automatic test_reset_wait();
      bit got;
      do_reset();
      req_data = '0; req_data[2*DW +: DW] = 8'h77;
      req = 4'b0100;
      exp_id.push_back(2); exp_data.push_back(8'h77);
      wait_send(got);
      assertions++; if (!got) begin failures++; $display("FAIL rw_send: no send seen"); end
      repeat (3) tick();
      rst = 1'b0; req = '0;
      #1;
      assertions++; if ({send, busy, ack, tx_err, gnt_id, dintx} !== '0) begin failures++; $display("FAIL rw_outputs_async: got %b want 0", {send, busy, ack, tx_err, gnt_id, dintx}); end
      tick();
      assertions++; if ({send, busy, ack, tx_err, gnt_id, dintx} !== '0) begin failures++; $display("FAIL rw_outputs_held: got %b want 0", {send, busy, ack, tx_err, gnt_id, dintx}); end
      tick();
      rst = 1'b1;
      donetx = 1'b1;
      tick();
      donetx = 1'b0;
      assertions++; if ({ack, busy} !== 5'b0) begin failures++; $display("FAIL rw_late_donetx: ack/busy got %b want 00000", {ack, busy}); end
      req_data[DW +: DW] = 8'hB1; req_data[3*DW +: DW] = 8'hD3;
      req = 4'b1010;
      exp_id.push_back(1); exp_data.push_back(8'hB1);
      respond(3, got);
      assertions++; if (!got) begin failures++; $display("FAIL rw_regrant_send: no send seen"); end
      assertions++; if (ack !== 4'b0010) begin failures++; $display("FAIL rw_regrant_ack: got %b want 0010", ack); end
      req = '0;
      repeat (4) tick();
   endtask

   task automatic test_data_stable();
      bit got;
      int bad;
      do_reset();
      req_data = '0; req_data[0 +: DW] = 8'hC3;
      req = 4'b0001;
      exp_id.push_back(0); exp_data.push_back(8'hC3);
      wait_send(got);
      assertions++; if (!got) begin failures++; $display("FAIL ds_send: no send seen"); end
      req_data[0 +: DW] = 8'h3C;
      bad = 0;
      repeat (5) begin
         tick();
         if (dintx !== 8'hC3) bad++;
      end
      assertions++; if (bad != 0) begin failures++; $display("FAIL ds_hold: %0d cycles with dintx != C3, want 0", bad); end
      donetx = 1'b1;
      tick();
      donetx = 1'b0;
      assertions++; if (dintx !== 8'hC3) begin failures++; $display("FAIL ds_done_dintx: got %h want c3", dintx); end
      assertions++; if (ack !== 4'b0001) begin failures++; $display("FAIL ds_ack: got %b want 0001", ack); end
      req = '0;
      repeat (4) tick();
   endtask

   task automatic test_scoreboard();
      int id;
      logic [7:0] d;
      int n;
      assertions++; if (mon_id.size() != exp_id.size()) begin failures++; $display("FAIL sb_count: got %0d sends want %0d", mon_id.size(), exp_id.size()); end
      n = 0;
      while (exp_id.size() > 0 && mon_id.size() > 0) begin
         id = exp_id.pop_front(); d = exp_data.pop_front();
         assertions++; if (mon_id[0] != id) begin failures++; $display("FAIL sb_gnt_%0d: got %0d want %0d", n, mon_id[0], id); end
         assertions++; if (mon_data[0] !== d) begin failures++; $display("FAIL sb_data_%0d: got %h want %h", n, mon_data[0], d); end
         void'(mon_id.pop_front()); void'(mon_data.pop_front());
         n++;
      end
      assertions++; if (viol != 0) begin failures++; $display("FAIL ack_err_exclusive: %0d bad cycles want 0", viol); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_timeout();
      test_reset_wait();
      test_data_stable();
      test_scoreboard();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
